// File: rtl/daw_pkg.sv
// Shared definitions for the DAW output gain stages: gain scaling constants,
// the gain ramp state encoding and the audio sample type.
package daw_pkg;

  localparam int GAIN_UNITY = 8;
  localparam int GAIN_SHIFT = 3;

  typedef enum logic [1:0] {
    STEADY,
    MUTED,
    RAMP_UP,
    RAMP_DOWN
  } gain_state_t;

  typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/master_out_sat_shift.sv
// sat_shift: combinational arithmetic shift-right of a wide gain product,
// saturated to OUT_W bits, with a flag raised whenever saturation occurs.
module sat_shift
  import daw_pkg::*;
#(
  parameter int IN_W  = 21,
  parameter int OUT_W = 16,
  parameter int SHIFT = GAIN_SHIFT
) (
  input  logic signed [IN_W-1:0]  i_prod,
  output logic signed [OUT_W-1:0] o_data,
  output logic                    o_clip
);

  logic signed [IN_W-1:0] w_shifted;
  logic signed [IN_W-1:0] w_max;
  logic signed [IN_W-1:0] w_min;

  // Arithmetic shift floors toward minus infinity, so -1 * 1 / 8 stays -1.
  assign w_shifted = i_prod >>> SHIFT;
  assign w_max     = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  assign w_min     = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    o_clip = 1'b0;
    o_data = w_shifted[OUT_W-1:0];
    if (w_shifted > w_max) begin
      o_data = {1'b0, {(OUT_W-1){1'b1}}};
      o_clip = 1'b1;
    end else if (w_shifted < w_min) begin
      o_data = {1'b1, {(OUT_W-1){1'b0}}};
      o_clip = 1'b1;
    end
  end

endmodule

// File: rtl/master_out.sv
// master_out: ramped master gain, saturation and held clip indicator.
// Define MASTER_OUT_CLIP_HOLD_EN to build the clip hold counter; otherwise clip_out is 0.
module master_out
  import daw_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int GAIN_BITS = 4,
  parameter int CLIP_HOLD = 4800
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        sample_valid_in,
  input  logic signed [WIDTH-1:0]     data_in,
  input  logic        [GAIN_BITS-1:0] master_gain,
  input  logic                        mute_in,
  output logic signed [WIDTH-1:0]     data_out,
  output logic                        data_valid_out,
  output logic                        clip_out,
  output logic        [GAIN_BITS-1:0] gain_out
);

  localparam int PROD_W = WIDTH + GAIN_BITS + 1;

  gain_state_t                w_state;
  logic [GAIN_BITS-1:0]       w_target;
  logic [GAIN_BITS-1:0]       w_cur_nxt;
  logic [GAIN_BITS-1:0]       r_cur;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [PROD_W-1:0]   r_prod;
  logic                       r_v1;
  logic signed [WIDTH-1:0]    w_sat;
  logic                       w_clip;
  logic signed [WIDTH-1:0]    r_data;
  logic                       r_valid;

  assign w_target = mute_in ? '0 : master_gain;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cur <= '0;
    end else begin
      r_cur <= w_cur_nxt;
    end
  end

  // Classify against the target seen this cycle; step only on a sample strobe.
  always_comb begin
    w_state = STEADY;
    if (r_cur < w_target) begin
      w_state = RAMP_UP;
    end else if (r_cur > w_target) begin
      w_state = RAMP_DOWN;
    end else if (w_target == '0) begin
      w_state = MUTED;
    end
    w_cur_nxt = r_cur;
    if (sample_valid_in) begin
      case (w_state)
        RAMP_UP:   w_cur_nxt = r_cur + GAIN_BITS'(1);
        RAMP_DOWN: w_cur_nxt = r_cur - GAIN_BITS'(1);
        STEADY,
        MUTED:     w_cur_nxt = r_cur;
        default:   w_cur_nxt = r_cur;
      endcase
    end
  end

  always_comb begin
    gain_out = r_cur;
  end

  // The sample is scaled by the gain in force before this strobe's step.
  assign w_prod = PROD_W'(data_in) * PROD_W'($signed({1'b0, r_cur}));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_prod <= '0;
      r_v1   <= 1'b0;
    end else begin
      r_v1 <= sample_valid_in;
      if (sample_valid_in) begin
        r_prod <= w_prod;
      end
    end
  end

  sat_shift #(
    .IN_W  (PROD_W),
    .OUT_W (WIDTH),
    .SHIFT (GAIN_SHIFT)
  ) u_sat (
    .i_prod (r_prod),
    .o_data (w_sat),
    .o_clip (w_clip)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_v1;
      if (r_v1) begin
        r_data <= w_sat;
      end
    end
  end

  assign data_out       = r_data;
  assign data_valid_out = r_valid;

`ifdef MASTER_OUT_CLIP_HOLD_EN
  localparam int HOLD_W = $clog2(CLIP_HOLD + 1);

  logic [HOLD_W-1:0] r_hold;

  // A fresh clip reloads the hold even if a strobe would decrement it this cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_hold <= '0;
    end else if (r_v1 && w_clip) begin
      r_hold <= HOLD_W'(CLIP_HOLD);
    end else if (sample_valid_in && (r_hold != '0)) begin
      r_hold <= r_hold - HOLD_W'(1);
    end
  end

  assign clip_out = (r_hold != '0);
`else
  logic [1:0] w_unused_bits;

  assign w_unused_bits = {w_clip, (CLIP_HOLD > 0)};
  assign clip_out      = 1'b0;
`endif

endmodule

// File: tb/tb_master_out.sv
// Scoreboard bench for master_out: directed strobes push hand-computed
// expectations, a negedge monitor pops and compares on every data_valid_out.
module tb_master_out;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               sample_valid_in;
  logic signed [15:0] data_in;
  logic        [3:0]  master_gain;
  logic               mute_in;
  logic signed [15:0] data_out;
  logic               data_valid_out;
  logic               clip_out;
  logic        [3:0]  gain_out;

`ifdef MASTER_OUT_CLIP_HOLD_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef struct {
    logic signed [15:0] d;
    logic               c;
    int                 cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  int fadeExp[10]  = '{0, 125, 250, 375, 500, 625, 750, 875, 1000, 1000};
  int fadeGain[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8};
  int b2bVals[8]   = '{16384, -16384, 12000, -12000, 1, -1, -32768, 32767};
  int muteIn[16]   = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  int muteExp[16]  = '{800, 700, 600, 500, 600, 700, 800,
                       800, 700, 600, 500, 400, 300, 200, 100, 0};
  int muteGain[16] = '{7, 6, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0};
  int clipIn[7]    = '{20000, -20000, 100, -100, 100, -100, -1};
  int clipExp[7]   = '{32767, -32768, 187, -188, 187, -188, -2};
  int clipFlag[7]  = '{1, 1, 1, 1, 1, 0, 0};

  master_out #(
    .WIDTH     (16),
    .GAIN_BITS (4),
    .CLIP_HOLD (4)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_valid_in (sample_valid_in),
    .data_in         (data_in),
    .master_gain     (master_gain),
    .mute_in         (mute_in),
    .data_out        (data_out),
    .data_valid_out  (data_valid_out),
    .clip_out        (clip_out),
    .gain_out        (gain_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input int d, input int g, input bit m,
                               input int expD, input bit expC, input int gap);
    exp_t e;
    sample_valid_in = 1'b1;
    data_in         = 16'(d);
    master_gain     = 4'(g);
    mute_in         = m;
    e.d   = 16'(expD);
    e.c   = expC & CLIP_EN;
    e.cyc = cyc + 2;
    q.push_back(e);
    @(posedge clk_in); #1;
    sample_valid_in = 1'b0;
    repeat (gap) begin
      @(posedge clk_in); #1;
    end
  endtask

  // Monitor: every output strobe must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (data_valid_out === 1'b1) begin
      exp_t e;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid: got data_out=%0d, expected no valid", data_out);
      end else begin
        e = q.pop_front();
        checkOutput("data_out", data_out, e.d);
        checkOutput("clip_out", clip_out, e.c);
        checkOutput("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_in          = 1'b1;
    sample_valid_in = 1'b0;
    data_in         = '0;
    master_gain     = 4'd8;
    mute_in         = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("reset_data", data_out, 0);
    checkOutput("reset_valid", data_valid_out, 0);
    checkOutput("reset_clip", clip_out, 0);
    checkOutput("reset_gain", gain_out, 0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    // Fade in from silence to unity.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1000, 8, 1'b0, fadeExp[k], 1'b0, 1);
      checkOutput("fade_gain", gain_out, fadeGain[k]);
    end

    // Full-rate strobes at unity gain pass the input through.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(b2bVals[k], 8, 1'b0, b2bVals[k], 1'b0, 0);
    end
    repeat (3) begin
      @(posedge clk_in); #1;
    end
    checkOutput("b2b_gain", gain_out, 8);

    // Mute ramp, interrupted at 5, then a full ramp down to MUTED.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(800, 8, muteIn[k][0], muteExp[k], 1'b0, 1);
      checkOutput("mute_gain", gain_out, muteGain[k]);
    end

    // Ramp up to full scale gain 15 on silent samples.
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(0, 15, 1'b0, 0, 1'b0, 1);
      checkOutput("ramp15_gain", gain_out, (k > 15) ? 15 : k);
    end

    // Saturation both ways, then the hold runs out over four clean strobes.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(clipIn[k], 15, 1'b0, clipExp[k], clipFlag[k][0], 1);
    end

    // Reset one cycle after a strobe discards that sample.
    applyStimulus(20000, 15, 1'b0, 32767, 1'b1, 1);
    sample_valid_in = 1'b1;
    data_in         = 16'sd1000;
    @(posedge clk_in); #1;
    sample_valid_in = 1'b0;
    rst_in          = 1'b1;
    @(posedge clk_in); #1;
    checkOutput("rst_data", data_out, 0);
    checkOutput("rst_valid", data_valid_out, 0);
    checkOutput("rst_clip", clip_out, 0);
    checkOutput("rst_gain", gain_out, 0);
    rst_in = 1'b0;
    repeat (4) begin
      @(posedge clk_in); #1;
    end

    applyStimulus(1000, 8, 1'b0, 0, 1'b0, 1);
    checkOutput("post_rst_gain", gain_out, 1);
    applyStimulus(1000, 8, 1'b0, 125, 1'b0, 1);
    checkOutput("post_rst_gain", gain_out, 2);

    for (int k = 0; k < 20 && q.size() != 0; k++) begin
      @(posedge clk_in); #1;
    end
    checkOutput("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
